vertex_fetch: RTL and testbench

Vertex source for the geometry pipeline. On a start pulse it walks a vertex list held in block RAM and reads packed (x, y, z) IEEE-754 single-precision coordinates. It emits each vertex as a homogeneous 4-vector [x, y, z, 1.0], using a valid/ready handshake with a small output buffer. It sits directly upstream of `transformation` and drives its `pos` / `valid_in`.

---
 rtl/vertex_fetch_if.sv | 20 ++
 rtl/vertex_fetch.sv | 155 +++++++++++++++
 tb/tb_vertex_fetch.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_fetch_if.sv
// Vertex output stream: homogeneous position, source index and last flag with a valid/ready handshake.
interface vertex_fetch_if #(
  parameter int ADDR_W = 8
);
  logic [3:0][31:0]   pos_out;
  logic [ADDR_W-1:0]  idx_out;
  logic               last_out;
  logic               valid_out;
  logic               ready_in;

  modport master (
    output pos_out, idx_out, last_out, valid_out,
    input  ready_in
  );

  modport slave (
    input  pos_out, idx_out, last_out, valid_out,
    output ready_in
  );
endinterface

// File: rtl/vertex_fetch.sv
// Walks a vertex list in block RAM and emits each (x, y, z) as [x, y, z, 1.0]
// through a 4-entry buffer, issuing reads only while buffer plus in-flight slots remain free.
module vertex_fetch #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W:0]   vert_count_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [95:0]       rd_data_in,
  output logic              busy_out,
  output logic              done_out,
  vertex_fetch_if.master    vout
);

  localparam logic [31:0] ONE_F = 32'h3f800000;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } tag_t;

  typedef struct packed {
    logic [31:0]       x;
    logic [31:0]       y;
    logic [31:0]       z;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [2:0]        count_q, count_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  tag_t              pipe_q [RD_LAT];
  tag_t              pipe_d [RD_LAT];
  entry_t            fifo_q [4];

  logic [2:0]        inflight;
  logic [3:0]        occupancy;
  logic              issue;
  logic              last_ptr;
  logic              push;
  logic              pop;
  logic              head_valid;
  entry_t            head;
  entry_t            entry_in;

  // A read is only issued when its returning data is guaranteed a buffer slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 3'(pipe_q[i].valid);
    end
    occupancy  = {1'b0, count_q} + {1'b0, inflight};
    issue      = (state_q == FETCH) && (occupancy < 4'd4);
    last_ptr   = (ptr_q == (n_q - (ADDR_W+1)'(1)));
    push       = pipe_q[RD_LAT-1].valid;
    head_valid = (count_q != 3'd0);
    pop        = head_valid && vout.ready_in;
    head       = fifo_q[rd_ptr_q];

    entry_in.x    = rd_data_in[95:64];
    entry_in.y    = rd_data_in[63:32];
    entry_in.z    = rd_data_in[31:0];
    entry_in.idx  = pipe_q[RD_LAT-1].idx;
    entry_in.last = pipe_q[RD_LAT-1].last;

    state_d = state_q;
    n_d     = n_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          n_d     = vert_count_in;
          ptr_d   = '0;
          state_d = (vert_count_in == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          ptr_d = ptr_q + (ADDR_W+1)'(1);
          if (last_ptr) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pipe_d[0].valid = issue;
    pipe_d[0].idx   = ptr_q[ADDR_W-1:0];
    pipe_d[0].last  = last_ptr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      n_q      <= '0;
      ptr_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= entry_in;
  end

  assign rd_en_out = issue;
  assign addr_out  = issue ? ptr_q[ADDR_W-1:0] : '0;
  assign busy_out  = (state_q == FETCH) || (state_q == DRAIN);
  assign done_out  = (state_q == DONE);

  assign vout.valid_out = head_valid;
  assign vout.pos_out   = {ONE_F,
                           head_valid ? head.z : 32'h0,
                           head_valid ? head.y : 32'h0,
                           head_valid ? head.x : 32'h0};
  assign vout.idx_out   = head_valid ? head.idx : '0;
  assign vout.last_out  = head_valid && head.last;

endmodule

// File: tb/tb_vertex_fetch.sv
// Directed bench for vertex_fetch: a 2-cycle RAM model feeds the DUT while a
// negedge monitor scores every transfer against the RAM contents and timing.
module tb_vertex_fetch;

  localparam int ADDR_W = 8;

  logic              clk_in;
  logic              rst_in;
  logic              start_in;
  logic [ADDR_W:0]   vert_count_in;
  logic              rd_en_out;
  logic [ADDR_W-1:0] addr_out;
  logic [95:0]       rd_data_in;
  logic              busy_out;
  logic              done_out;

  vertex_fetch_if #(.ADDR_W(ADDR_W)) vout ();

  vertex_fetch #(.ADDR_W(ADDR_W), .RD_LAT(2)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .vert_count_in (vert_count_in),
    .rd_en_out     (rd_en_out),
    .addr_out      (addr_out),
    .rd_data_in    (rd_data_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .vout          (vout.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e_cyc = 0;

  logic [95:0] ram [256];
  logic [95:0] rd_pipe;

  int          mon_n;
  int          mon_exp_idx;
  int          rd_cnt;
  int          beats;
  int          last_cnt;
  int          done_cnt;
  int          first_rd_rel;
  int          first_valid_rel;
  int          first_busy_rel;
  int          last_xfer_rel;
  int          done_rel;
  bit          valid_seen;
  bit          busy_seen;
  bit          done_seen;
  bit          busy_at_last;
  bit          busy_at_done;
  bit          prev_hold;
  logic [127:0] prev_pos;
  logic [127:0] prev_idx;
  logic [127:0] beat_pos [3];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    rd_pipe    <= rd_en_out ? ram[addr_out] : 96'h0;
    rd_data_in <= rd_pipe;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] expPos(input int i);
    return {32'h3f800000, ram[i][31:0], ram[i][63:32], ram[i][95:64]};
  endfunction

  task automatic clearMonitor(input int n);
    mon_n           = n;
    mon_exp_idx     = 0;
    rd_cnt          = 0;
    beats           = 0;
    last_cnt        = 0;
    done_cnt        = 0;
    first_rd_rel    = -1;
    first_valid_rel = -1;
    first_busy_rel  = -1;
    last_xfer_rel   = -1;
    done_rel        = -1;
    valid_seen      = 0;
    busy_seen       = 0;
    done_seen       = 0;
    busy_at_last    = 0;
    busy_at_done    = 1;
  endtask

  always @(negedge clk_in) begin
    int rel;
    rel = cyc - e_cyc + 1;
    if (!rst_in) begin
      prev_hold = 0;
    end else begin
      if (rd_en_out) begin
        if (rd_cnt == 0) first_rd_rel = rel;
        checkOutput("rd_addr", 128'(addr_out), 128'(rd_cnt));
        rd_cnt++;
      end
      if (busy_out && !busy_seen) begin
        busy_seen      = 1;
        first_busy_rel = rel;
      end
      if (vout.valid_out && !valid_seen) begin
        valid_seen      = 1;
        first_valid_rel = rel;
      end
      if (prev_hold) begin
        checkOutput("hold_pos", vout.pos_out, prev_pos);
        checkOutput("hold_idx", 128'(vout.idx_out), prev_idx);
      end
      prev_hold = vout.valid_out && !vout.ready_in;
      prev_pos  = vout.pos_out;
      prev_idx  = 128'(vout.idx_out);
      if (vout.valid_out && vout.ready_in) begin
        checkOutput("beat_idx", 128'(vout.idx_out), 128'(mon_exp_idx));
        checkOutput("beat_pos", vout.pos_out, expPos(mon_exp_idx % 256));
        checkOutput("beat_last", 128'(vout.last_out), 128'(mon_exp_idx == mon_n - 1));
        if (beats < 3) beat_pos[beats] = vout.pos_out;
        if (vout.last_out) last_cnt++;
        last_xfer_rel = rel;
        busy_at_last  = busy_out;
        mon_exp_idx++;
        beats++;
      end
      if (done_out) begin
        done_cnt++;
        done_seen    = 1;
        done_rel     = rel;
        busy_at_done = busy_out;
      end
    end
  end

  // Pulses start for one cycle from the current cycle; returns #1 into cycle E+1.
  task automatic applyStimulus(input int n);
    clearMonitor(n);
    start_in      = 1'b1;
    vert_count_in = (ADDR_W+1)'(n);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    e_cyc    = cyc;
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (!done_seen && k < budget) begin
      @(posedge clk_in);
      k++;
    end
    #1;
    checkOutput("done_timeout", 128'(done_seen), 128'(1));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = {32'h41000000 + 32'(i), 32'hA5A50000 ^ 32'(i * 7), (32'(i) << 8) | 32'h1};
    end
    ram[0] = {32'h3f800000, 32'h40000000, 32'h40400000};
    ram[1] = {32'h40000000, 32'h40000000, 32'h40400000};
    ram[2] = {32'h40400000, 32'h40000000, 32'h40400000};

    rst_in        = 1'b0;
    start_in      = 1'b0;
    vert_count_in = '0;
    vout.ready_in = 1'b1;
    clearMonitor(0);

    #12;
    checkOutput("rst_rd_en", 128'(rd_en_out), 128'(0));
    checkOutput("rst_addr", 128'(addr_out), 128'(0));
    checkOutput("rst_valid", 128'(vout.valid_out), 128'(0));
    checkOutput("rst_idx_last", 128'({vout.idx_out, vout.last_out}), 128'(0));
    checkOutput("rst_busy_done", 128'({busy_out, done_out}), 128'(0));
    checkOutput("rst_pos", vout.pos_out, 128'h3f800000_00000000_00000000_00000000);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    $display("[TB] basic pass N=3");
    applyStimulus(3);
    waitDone(50);
    checkOutput("basic_first_rd", 128'(first_rd_rel), 128'(1));
    checkOutput("basic_first_valid", 128'(first_valid_rel), 128'(4));
    checkOutput("basic_last_xfer", 128'(last_xfer_rel), 128'(6));
    checkOutput("basic_done", 128'(done_rel), 128'(7));
    checkOutput("basic_first_busy", 128'(first_busy_rel), 128'(1));
    checkOutput("basic_busy_last", 128'(busy_at_last), 128'(1));
    checkOutput("basic_busy_done", 128'(busy_at_done), 128'(0));
    checkOutput("basic_beats", 128'(beats), 128'(3));
    checkOutput("basic_reads", 128'(rd_cnt), 128'(3));
    checkOutput("basic_last_cnt", 128'(last_cnt), 128'(1));
    checkOutput("basic_pos0", beat_pos[0], 128'h3f800000_40400000_40000000_3f800000);
    checkOutput("basic_pos1", beat_pos[1], 128'h3f800000_40400000_40000000_40000000);
    checkOutput("basic_pos2", beat_pos[2], 128'h3f800000_40400000_40000000_40400000);

    $display("[TB] zero length, started in the idle cycle right after done");
    applyStimulus(0);
    waitDone(20);
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("zero_done", 128'(done_rel), 128'(1));
    checkOutput("zero_done_cnt", 128'(done_cnt), 128'(1));
    checkOutput("zero_reads", 128'(rd_cnt), 128'(0));
    checkOutput("zero_valid", 128'(valid_seen), 128'(0));
    checkOutput("zero_busy", 128'(busy_seen), 128'(0));

    $display("[TB] backpressure N=16");
    applyStimulus(16);
    vout.ready_in = 1'b0;
    repeat (12) @(posedge clk_in);
    #1;
    checkOutput("bp_reads_held", 128'(rd_cnt), 128'(4));
    checkOutput("bp_rd_en_low", 128'(rd_en_out), 128'(0));
    checkOutput("bp_valid_held", 128'(vout.valid_out), 128'(1));
    checkOutput("bp_no_beats", 128'(beats), 128'(0));
    @(posedge clk_in);
    #1;
    vout.ready_in = 1'b1;
    waitDone(100);
    checkOutput("bp_beats", 128'(beats), 128'(16));
    checkOutput("bp_reads", 128'(rd_cnt), 128'(16));
    checkOutput("bp_last_cnt", 128'(last_cnt), 128'(1));

    $display("[TB] random ready N=256");
    begin
      int k = 0;
      applyStimulus(256);
      while (!done_seen && k < 4000) begin
        @(posedge clk_in);
        #1;
        vout.ready_in = 1'($urandom_range(0, 1));
        k++;
      end
      checkOutput("rand_timeout", 128'(done_seen), 128'(1));
      vout.ready_in = 1'b1;
    end
    checkOutput("rand_beats", 128'(beats), 128'(256));
    checkOutput("rand_reads", 128'(rd_cnt), 128'(256));
    checkOutput("rand_last_cnt", 128'(last_cnt), 128'(1));
    repeat (2) @(posedge clk_in);
    #1;

    $display("[TB] start while busy");
    applyStimulus(5);
    repeat (2) @(posedge clk_in);
    #1;
    start_in      = 1'b1;
    vert_count_in = 9'd9;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    waitDone(50);
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("busy_start_beats", 128'(beats), 128'(5));
    checkOutput("busy_start_reads", 128'(rd_cnt), 128'(5));
    checkOutput("busy_start_done_cnt", 128'(done_cnt), 128'(1));

    $display("[TB] reset mid-pass");
    applyStimulus(16);
    vout.ready_in = 1'b0;
    @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    #1;
    checkOutput("midrst_rd_en", 128'(rd_en_out), 128'(0));
    checkOutput("midrst_valid", 128'(vout.valid_out), 128'(0));
    checkOutput("midrst_busy_done", 128'({busy_out, done_out}), 128'(0));
    checkOutput("midrst_pos", vout.pos_out, 128'h3f800000_00000000_00000000_00000000);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in        = 1'b1;
    vout.ready_in = 1'b1;
    clearMonitor(0);
    repeat (6) @(posedge clk_in);
    #1;
    checkOutput("midrst_no_stale", 128'(valid_seen), 128'(0));
    applyStimulus(2);
    waitDone(50);
    checkOutput("midrst_beats", 128'(beats), 128'(2));
    checkOutput("midrst_reads", 128'(rd_cnt), 128'(2));
    checkOutput("midrst_first_valid", 128'(first_valid_rel), 128'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
